// File: rtl/clock_pkg.sv
// Constants and types shared by the digital-clock stages and the display driver.
// bcd_t is laid out tens-first so that it maps MSB-first onto the count_bcd port.
package clock_pkg;

  localparam int SIXTY_MODULUS = 60;
  localparam int SIXTY_WIDTH   = 6;

  typedef struct packed {
    logic [2:0] tens;
    logic [3:0] ones;
  } bcd_t;

  function automatic bcd_t to_bcd(input logic [SIXTY_WIDTH-1:0] v);
    bcd_t b;
    b.tens = 3'(v / SIXTY_WIDTH'(10));
    b.ones = 4'(v % SIXTY_WIDTH'(10));
    return b;
  endfunction

endpackage

// File: rtl/sixty_edge_det.sv
// Rising-edge detector: previous-value flop plus a one-cycle pulse.
// The flop tracks the input during reset, so a level held across release gives no edge.
module sixty_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic in_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge Clk) begin
    prev_q <= in_i;
  end

  assign edge_o = in_i & ~prev_q & ~Reset;

endmodule

// File: rtl/sixty_counter.sv
// Modulo-MODULUS counter with tick, add and subtract edges and a registered carry pulse.
// Define SIXTY_BCD_EN to add the registered count_bcd output (tens/ones digits).
module sixty_counter
  import clock_pkg::*;
#(
  parameter int MODULUS = SIXTY_MODULUS,
  parameter int WIDTH   = SIXTY_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Sixty_in,
  input  logic             Add,
  input  logic             Subtract,
  output logic             Sixty_out,
  output logic [0:WIDTH-1] count
`ifdef SIXTY_BCD_EN
  ,
  output logic [0:6]       count_bcd
`endif
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);

  logic             tick_e, add_e, sub_e;
  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   up_sum, raw_sum, wrapped;

  function automatic logic [WIDTH:0] wrap_mod(input logic [WIDTH:0] v);
    return (v >= MOD_W) ? v - MOD_W : v;
  endfunction

  sixty_edge_det u_tick (.Clk(Clk), .Reset(Reset), .in_i(Sixty_in), .edge_o(tick_e));
  sixty_edge_det u_add  (.Clk(Clk), .Reset(Reset), .in_i(Add),      .edge_o(add_e));
  sixty_edge_det u_sub  (.Clk(Clk), .Reset(Reset), .in_i(Subtract), .edge_o(sub_e));

  // Stage 0: combine edges into the next count; carry only when a tick crosses MODULUS
  always_comb begin
    up_sum  = {1'b0, count_q} + {{WIDTH{1'b0}}, tick_e} + {{WIDTH{1'b0}}, add_e};
    raw_sum = up_sum;
    if (sub_e) begin
      raw_sum = (up_sum == '0) ? MAX_W : up_sum - 1'b1;
    end
    wrapped = wrap_mod(raw_sum);
    count_d = wrapped[WIDTH-1:0];
    carry_d = tick_e & (raw_sum >= MOD_W);
  end

`ifdef SIXTY_BCD_EN
  bcd_t bcd_q;
`endif

  // Stage 1: registered count, carry and optional BCD digits
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
`ifdef SIXTY_BCD_EN
      bcd_q   <= '0;
`endif
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
`ifdef SIXTY_BCD_EN
      bcd_q   <= to_bcd(SIXTY_WIDTH'(count_d));
`endif
    end
  end

  assign count     = count_q;
  assign Sixty_out = carry_q;
`ifdef SIXTY_BCD_EN
  assign count_bcd = bcd_q;
`endif

endmodule

// File: tb/tb_sixty_counter.sv
// Self-checking bench for sixty_counter: directed scenarios plus random stimulus
// compared each cycle against a modulo-arithmetic reference model.
module tb_sixty_counter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Sixty_in = 1'b0;
  logic       Add = 1'b0;
  logic       Subtract = 1'b0;
  logic       Sixty_out;
  logic [0:5] count;
`ifdef SIXTY_BCD_EN
  logic [0:6] count_bcd;
`endif

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_count = 0;
  int m_carry = 0;
  bit m_pt = 1'b0, m_pa = 1'b0, m_ps = 1'b0;
  int m_sum;

  sixty_counter dut (
    .Clk(Clk), .Reset(Reset), .Sixty_in(Sixty_in), .Add(Add), .Subtract(Subtract),
    .Sixty_out(Sixty_out), .count(count)
`ifdef SIXTY_BCD_EN
    , .count_bcd(count_bcd)
`endif
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Reset) begin
      m_count = 0;
      m_carry = 0;
    end else begin
      m_sum   = m_count + int'(Sixty_in && !m_pt) + int'(Add && !m_pa) - int'(Subtract && !m_ps);
      m_carry = (Sixty_in && !m_pt && m_sum >= 60) ? 1 : 0;
      m_count = ((m_sum % 60) + 60) % 60;
    end
    m_pt = Sixty_in;
    m_pa = Add;
    m_ps = Subtract;
  end

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic pulse(input bit t, input bit a, input bit s);
    Sixty_in = t; Add = a; Subtract = s;
    cyc();
    Sixty_in = 1'b0; Add = 1'b0; Subtract = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Sixty_in = 1'b1;
    repeat (3) cyc();
    checks++;
    if (count !== 6'd0 || Sixty_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state count=%0d carry=%0b required count=0 carry=0", count, Sixty_out);
    end
    Reset = 1'b0;
    repeat (5) cyc();
    checks++;
    if (count !== 6'd0 || Sixty_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_tick count=%0d carry=%0b required count=0 carry=0", count, Sixty_out);
    end
    Sixty_in = 1'b0;
    cyc();
  endtask

  task automatic test_tick_sweep();
    int highs = 0;
    int exp_cnt = 0;
    for (int e = 0; e < 60; e++) begin
      for (int c = 0; c < 20; c++) begin
        Sixty_in = (c < 10);
        cyc();
        if (c == 0) exp_cnt = (exp_cnt + 1) % 60;
        checks++;
        if (count !== 6'(exp_cnt) || Sixty_out !== (m_carry != 0)) begin
          errors++;
          $display("FAIL tick_sweep edge=%0d count=%0d carry=%0b required count=%0d carry=%0b",
                   e, count, Sixty_out, exp_cnt, m_carry);
        end
        if (Sixty_out === 1'b1) begin
          highs++;
          checks++;
          if (count !== 6'd0) begin
            errors++;
            $display("FAIL carry_alignment count=%0d required 0", count);
          end
        end
      end
    end
    Sixty_in = 1'b0;
    checks++;
    if (highs != 1) begin
      errors++;
      $display("FAIL carry_count highs=%0d required 1", highs);
    end
  endtask

  task automatic test_add_wrap();
    pulse(1'b0, 1'b0, 1'b1);
    checks++;
    if (count !== 6'd59 || Sixty_out !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap count=%0d carry=%0b required count=59 carry=0", count, Sixty_out);
    end
    Add = 1'b1;
    cyc();
    checks++;
    if (count !== 6'd0 || Sixty_out !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap count=%0d carry=%0b required count=0 carry=0", count, Sixty_out);
    end
    Add = 1'b0;
    cyc();
    pulse(1'b0, 1'b0, 1'b1);
    checks++;
    if (count !== 6'd59 || Sixty_out !== 1'b0) begin
      errors++;
      $display("FAIL sub_after_add count=%0d carry=%0b required count=59 carry=0", count, Sixty_out);
    end
  endtask

  task automatic test_tick_add();
    pulse(1'b0, 1'b0, 1'b1);
    Sixty_in = 1'b1; Add = 1'b1;
    cyc();
    checks++;
    if (count !== 6'd0 || Sixty_out !== 1'b1) begin
      errors++;
      $display("FAIL tick_add_58 count=%0d carry=%0b required count=0 carry=1", count, Sixty_out);
    end
    Sixty_in = 1'b0; Add = 1'b0;
    cyc();
    checks++;
    if (Sixty_out !== 1'b0) begin
      errors++;
      $display("FAIL carry_width carry=%0b required 0", Sixty_out);
    end
    pulse(1'b0, 1'b0, 1'b1);
    Sixty_in = 1'b1; Add = 1'b1;
    cyc();
    checks++;
    if (count !== 6'd1 || Sixty_out !== 1'b1) begin
      errors++;
      $display("FAIL tick_add_59 count=%0d carry=%0b required count=1 carry=1", count, Sixty_out);
    end
    Sixty_in = 1'b0; Add = 1'b0;
    cyc();
  endtask

  task automatic test_cancel_hold();
    repeat (29) pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 6'd30) begin
      errors++;
      $display("FAIL add_steps count=%0d required 30", count);
    end
    pulse(1'b0, 1'b1, 1'b1);
    checks++;
    if (count !== 6'd30) begin
      errors++;
      $display("FAIL add_sub_cancel count=%0d required 30", count);
    end
    Add = 1'b1;
    repeat (20) cyc();
    Add = 1'b0;
    cyc();
    checks++;
    if (count !== 6'd31) begin
      errors++;
      $display("FAIL add_hold count=%0d required 31", count);
    end
  endtask

`ifdef SIXTY_BCD_EN
  task automatic test_bcd();
    repeat (16) pulse(1'b0, 1'b1, 1'b0);
    checks++;
    if (count !== 6'd47 || count_bcd !== {3'd4, 4'd7}) begin
      errors++;
      $display("FAIL bcd_47 count=%0d bcd=%b required count=47 bcd=%b", count, count_bcd, {3'd4, 4'd7});
    end
    repeat (12) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 6'd0 || count_bcd !== 7'd0) begin
      errors++;
      $display("FAIL bcd_wrap count=%0d bcd=%b required 0", count, count_bcd);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      Reset    = ($urandom_range(0, 99) == 0);
      Sixty_in = $urandom_range(0, 1) != 0;
      Add      = $urandom_range(0, 2) == 0;
      Subtract = $urandom_range(0, 2) == 0;
      cyc();
      checks++;
      if (count !== 6'(m_count) || Sixty_out !== (m_carry != 0)) begin
        errors++;
        $display("FAIL random_%0d count=%0d carry=%0b required count=%0d carry=%0b",
                 i, count, Sixty_out, m_count, m_carry);
      end
`ifdef SIXTY_BCD_EN
      checks++;
      if (count_bcd !== {3'(m_count / 10), 4'(m_count % 10)}) begin
        errors++;
        $display("FAIL random_bcd_%0d bcd=%b required %b", i, count_bcd,
                 {3'(m_count / 10), 4'(m_count % 10)});
      end
`endif
    end
    Reset = 1'b0; Sixty_in = 1'b0; Add = 1'b0; Subtract = 1'b0;
    cyc();
  endtask

  task automatic test_mid_reset();
    pulse(1'b0, 1'b1, 1'b0);
    Reset = 1'b1; Add = 1'b1;
    cyc();
    checks++;
    if (count !== 6'd0 || Sixty_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority count=%0d carry=%0b required 0", count, Sixty_out);
    end
    Reset = 1'b0;
    cyc();
    checks++;
    if (count !== 6'd0) begin
      errors++;
      $display("FAIL reset_release_held_add count=%0d required 0", count);
    end
    Add = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_tick_sweep();
    test_add_wrap();
    test_tick_add();
    test_cancel_hold();
`ifdef SIXTY_BCD_EN
    test_bcd();
`endif
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
